// File: rtl/uart_sched_pkg.sv
// Shared state encoding, flag-register bit position and default register map
// for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_REQ,
    S_POLL_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  localparam int unsigned FR_TXFF_BIT   = 5;
  localparam logic [31:0] UART_BASE_DEF = 32'h1600_0000;
  localparam logic [15:0] FR_OFFSET_DEF = 16'h0018;
  localparam logic [15:0] DR_OFFSET_DEF = 16'h0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the index after
// last_grant and wraps; returns a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned s = 1; s <= N; s++) begin
      k = IW'((32'(last_grant) + s) % N);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        index    = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler sharing one UART among N_REQ byte producers
// via Wishbone. Optional macro UART_SCHED_PRIO_EN makes requester 0 strict high priority.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter logic [31:0] UART_BASE = UART_BASE_DEF,
  parameter logic [15:0] FR_OFFSET = FR_OFFSET_DEF,
  parameter logic [15:0] DR_OFFSET = DR_OFFSET_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ack,
  output logic [31:0]        o_wb_adr,
  output logic [3:0]         o_wb_sel,
  output logic               o_wb_we,
  output logic [31:0]        o_wb_dat,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  input  logic [31:0]        i_wb_dat,
  input  logic               i_wb_ack,
  input  logic               i_wb_err,
  output logic               o_busy
);

  localparam int unsigned IW      = $clog2(N_REQ);
  localparam logic [31:0] FR_ADDR = UART_BASE + {16'd0, FR_OFFSET};
  localparam logic [31:0] DR_ADDR = UART_BASE + {16'd0, DR_OFFSET};

  state_t           state;
  logic             gap;
  logic [IW-1:0]    last_grant, winner, arb_idx, sel_idx;
  logic [N_REQ-1:0] arb_req, arb_grant, sel_oh, win_oh;
  logic [7:0]       byte_q;
  logic             unused_dat;

  assign unused_dat = ^{i_wb_dat[31:FR_TXFF_BIT+1], i_wb_dat[FR_TXFF_BIT-1:0]};
  assign o_wb_sel   = 4'hf;
  assign o_busy     = (state != S_IDLE);

`ifdef UART_SCHED_PRIO_EN
  // Requester 0 bypasses the rotation; the arbiter only sees the others.
  assign arb_req = {i_req_valid[N_REQ-1:1], 1'b0};
  assign sel_idx = i_req_valid[0] ? '0 : arb_idx;
  assign sel_oh  = i_req_valid[0] ? N_REQ'(1) : arb_grant;
`else
  assign arb_req = i_req_valid;
  assign sel_idx = arb_idx;
  assign sel_oh  = arb_grant;
`endif

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req        (arb_req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .index      (arb_idx)
  );

  // Bus outputs are loaded on the transition into each state so they are
  // registered and already valid during that state's first cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      gap        <= 1'b0;
      last_grant <= IW'(N_REQ - 1);
      winner     <= '0;
      win_oh     <= '0;
      byte_q     <= '0;
      o_req_ack  <= '0;
      o_wb_adr   <= '0;
      o_wb_dat   <= '0;
      o_wb_we    <= 1'b0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
    end else begin
      o_req_ack <= '0;
      case (state)
        S_IDLE: begin
          if (|i_req_valid) begin
            winner   <= sel_idx;
            win_oh   <= sel_oh;
            byte_q   <= i_req_data[8*sel_idx +: 8];
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_we  <= 1'b0;
            o_wb_adr <= FR_ADDR;
            state    <= S_POLL_REQ;
          end
        end
        S_POLL_REQ: state <= S_POLL_WAIT;
        S_POLL_WAIT: begin
          // A failed poll idles the bus for one cycle (gap) before re-polling.
          if (gap) begin
            gap      <= 1'b0;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            state    <= S_POLL_REQ;
          end else if (i_wb_err || (i_wb_ack && i_wb_dat[FR_TXFF_BIT])) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            gap      <= 1'b1;
          end else if (i_wb_ack) begin
            o_wb_we  <= 1'b1;
            o_wb_adr <= DR_ADDR;
            o_wb_dat <= {24'd0, byte_q};
            state    <= S_WR_REQ;
          end
        end
        S_WR_REQ: state <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (i_wb_err) begin
            o_wb_we  <= 1'b0;
            o_wb_adr <= FR_ADDR;
            state    <= S_POLL_REQ;
          end else if (i_wb_ack) begin
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_req_ack <= win_oh;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef UART_SCHED_PRIO_EN
          if (winner != '0) last_grant <= winner;
`else
          last_grant <= winner;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: Wishbone UART slave model with
// programmable FIFO-full / error responses and a round-robin reference model.
module tb_uart_tx_sched;

  localparam int          N    = 4;
  localparam logic [31:0] FR_A = 32'h1600_0018;
  localparam logic [31:0] DR_A = 32'h1600_0000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic [31:0]    wb_adr, wb_dat_o;
  logic [31:0]    wb_dat_i;
  logic [3:0]     wb_sel;
  logic           wb_we, wb_cyc, wb_stb, wb_ack, wb_err, busy;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ack   (req_ack),
    .o_wb_adr    (wb_adr),
    .o_wb_sel    (wb_sel),
    .o_wb_we     (wb_we),
    .o_wb_dat    (wb_dat_o),
    .o_wb_cyc    (wb_cyc),
    .o_wb_stb    (wb_stb),
    .i_wb_dat    (wb_dat_i),
    .i_wb_ack    (wb_ack),
    .i_wb_err    (wb_err),
    .o_busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int model_last = N - 1;

  // Slave configuration (written by tests) and consumption (written by slave).
  int wait_cfg = 0, full_budget = 0, err_budget = 0;
  int full_used = 0, err_used = 0, wait_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_err   <= 1'b0;
      wait_cnt <= 0;
      wb_dat_i <= '0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
        if (wait_cnt < wait_cfg) wait_cnt <= wait_cnt + 1;
        else begin
          wait_cnt <= 0;
          if (!wb_we) begin
            if (full_used < full_budget) begin
              full_used <= full_used + 1;
              wb_dat_i  <= $urandom | 32'h20;
            end else begin
              wb_dat_i <= $urandom & ~32'h20;
            end
            wb_ack <= 1'b1;
          end else if (err_used < err_budget) begin
            err_used <= err_used + 1;
            wb_err   <= 1'b1;
          end else begin
            wb_ack <= 1'b1;
          end
        end
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  // Bus monitor: handshake counters and protocol violation tally.
  int          fr_reads = 0, dr_writes = 0, gaps = 0, acks = 0, viol = 0;
  logic [31:0] last_wdat = '0;
  logic        pend = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else begin
      if ((pend && !(wb_cyc && wb_stb)) || (wb_sel !== 4'hf) ||
          (wb_cyc && wb_stb && (wb_ack || wb_err) &&
           (wb_we ? (wb_adr !== DR_A || wb_dat_o[31:8] !== 24'd0) : (wb_adr !== FR_A))))
        viol <= viol + 1;
      pend <= wb_cyc && wb_stb && !(wb_ack || wb_err);
      if (wb_cyc && wb_stb && (wb_ack || wb_err)) begin
        if (wb_we) begin
          dr_writes <= dr_writes + 1;
          last_wdat <= wb_dat_o;
        end else begin
          fr_reads <= fr_reads + 1;
        end
      end
      if (busy && !wb_cyc) gaps <= gaps + 1;
      if (req_ack != '0) acks <= acks + 1;
    end
  end

  function automatic int model_pick(input logic [N-1:0] v, input int last);
`ifdef UART_SCHED_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int s = 1; s <= N; s++) begin
      if (v[(last + s) % N]) return (last + s) % N;
    end
    return -1;
  endfunction

  function automatic int model_next_last(input int pick, input int last);
`ifdef UART_SCHED_PRIO_EN
    if (pick == 0) return last;
`endif
    return pick;
  endfunction

  // Steps negedges until an ack pulse; idx=-1 on timeout, -2 if not one-hot.
  task automatic wait_ack(input int budget, output int idx, output int cycles);
    idx = -1;
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (req_ack !== '0) begin
        idx = -2;
        if ($onehot(req_ack))
          for (int k = 0; k < N; k++) if (req_ack[k]) idx = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_vec++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) begin
      n_err++; $display("FAIL reset_ctl: got cyc/stb/we %0b%0b%0b want 000", wb_cyc, wb_stb, wb_we); end
    n_vec++; if (wb_adr !== 32'd0) begin n_err++; $display("FAIL reset_adr: got %h want 0", wb_adr); end
    n_vec++; if (wb_dat_o !== 32'd0) begin n_err++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
    n_vec++; if (wb_sel !== 4'hf) begin n_err++; $display("FAIL reset_sel: got %h want f", wb_sel); end
    n_vec++; if (req_ack !== '0) begin n_err++; $display("FAIL reset_ack: got %b want 0", req_ack); end
    rst_n = 1'b1;
    model_last = N - 1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_req: got busy %0b want 0", busy); end
  endtask

  task automatic test_single();
    int idx, cyc, fr0, dr0, g0;
    fr0 = fr_reads; dr0 = dr_writes; g0 = gaps;
    req_data[15:8] = 8'h41;
    req_valid = 4'b0010;
    wait_ack(50, idx, cyc);
    req_valid[1] = 1'b0;
    n_vec++; if (idx !== 1) begin n_err++; $display("FAIL single_idx: got %0d want 1", idx); end
    n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL single_latency: got %0d want 5", cyc); end
    n_vec++; if (fr_reads - fr0 !== 1) begin n_err++; $display("FAIL single_fr_reads: got %0d want 1", fr_reads - fr0); end
    n_vec++; if (dr_writes - dr0 !== 1) begin n_err++; $display("FAIL single_dr_writes: got %0d want 1", dr_writes - dr0); end
    n_vec++; if (last_wdat !== 32'h0000_0041) begin n_err++; $display("FAIL single_wdat: got %h want 00000041", last_wdat); end
    n_vec++; if (gaps - g0 !== 0) begin n_err++; $display("FAIL single_gaps: got %0d want 0", gaps - g0); end
    model_last = model_next_last(1, model_last);
    @(negedge clk);
    n_vec++; if (req_ack !== '0) begin n_err++; $display("FAIL single_ack_pulse: got %b want 0", req_ack); end
  endtask

  task automatic test_latch();
    int idx, cyc;
    logic [7:0] b;
    b = 8'($urandom);
    req_data[23:16] = b;
    req_valid = 4'b0100;
    repeat (2) @(negedge clk);
    req_data[23:16] = ~b;
    req_valid[2] = 1'b0;
    wait_ack(50, idx, cyc);
    n_vec++; if (idx !== 2) begin n_err++; $display("FAIL latch_idx: got %0d want 2", idx); end
    n_vec++; if (cyc + 2 !== 5) begin n_err++; $display("FAIL latch_latency: got %0d want 5", cyc + 2); end
    n_vec++; if (last_wdat !== {24'd0, b}) begin n_err++; $display("FAIL latch_wdat: got %h want %h", last_wdat, {24'd0, b}); end
    model_last = model_next_last(2, model_last);
    @(negedge clk);
  endtask

  task automatic test_fr_full();
    int idx, cyc, fr0, dr0, g0;
    logic [7:0] b;
    fr0 = fr_reads; dr0 = dr_writes; g0 = gaps;
    b = 8'($urandom);
    full_budget += 3;
    req_data[31:24] = b;
    req_valid = 4'b1000;
    wait_ack(100, idx, cyc);
    req_valid[3] = 1'b0;
    n_vec++; if (idx !== 3) begin n_err++; $display("FAIL full_idx: got %0d want 3", idx); end
    n_vec++; if (cyc !== 14) begin n_err++; $display("FAIL full_latency: got %0d want 14", cyc); end
    n_vec++; if (fr_reads - fr0 !== 4) begin n_err++; $display("FAIL full_fr_reads: got %0d want 4", fr_reads - fr0); end
    n_vec++; if (dr_writes - dr0 !== 1) begin n_err++; $display("FAIL full_dr_writes: got %0d want 1", dr_writes - dr0); end
    n_vec++; if (gaps - g0 !== 3) begin n_err++; $display("FAIL full_gaps: got %0d want 3", gaps - g0); end
    n_vec++; if (last_wdat !== {24'd0, b}) begin n_err++; $display("FAIL full_wdat: got %h want %h", last_wdat, {24'd0, b}); end
    model_last = model_next_last(3, model_last);
    @(negedge clk);
  endtask

  task automatic test_dr_err();
    int idx, cyc, fr0, dr0, a0;
    logic [7:0] b;
    fr0 = fr_reads; dr0 = dr_writes; a0 = acks;
    b = 8'($urandom);
    err_budget += 1;
    req_data[7:0] = b;
    req_valid = 4'b0001;
    wait_ack(100, idx, cyc);
    req_valid[0] = 1'b0;
    n_vec++; if (idx !== 0) begin n_err++; $display("FAIL err_idx: got %0d want 0", idx); end
    n_vec++; if (cyc !== 9) begin n_err++; $display("FAIL err_latency: got %0d want 9", cyc); end
    n_vec++; if (fr_reads - fr0 !== 2) begin n_err++; $display("FAIL err_fr_reads: got %0d want 2", fr_reads - fr0); end
    n_vec++; if (dr_writes - dr0 !== 2) begin n_err++; $display("FAIL err_dr_writes: got %0d want 2", dr_writes - dr0); end
    n_vec++; if (last_wdat !== {24'd0, b}) begin n_err++; $display("FAIL err_wdat: got %h want %h", last_wdat, {24'd0, b}); end
    model_last = model_next_last(0, model_last);
    repeat (12) @(negedge clk);
    n_vec++; if (acks - a0 !== 1) begin n_err++; $display("FAIL err_ack_count: got %0d want 1", acks - a0); end
  endtask

  task automatic test_round_robin();
    int idx, cyc, exp;
    logic [7:0] b;
    for (int k = 0; k < N; k++) req_data[8*k +: 8] = 8'($urandom);
    req_valid = '1;
    for (int t = 0; t < 2 * N; t++) begin
      exp = model_pick(req_valid, model_last);
      b = req_data[8*exp +: 8];
      wait_ack(60, idx, cyc);
      n_vec++; if (idx !== exp) begin n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", t, idx, exp); end
      n_vec++; if (cyc !== ((t == 0) ? 5 : 6)) begin
        n_err++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", t, cyc, (t == 0) ? 5 : 6); end
      n_vec++; if (last_wdat !== {24'd0, b}) begin n_err++; $display("FAIL rr_wdat[%0d]: got %h want %h", t, last_wdat, {24'd0, b}); end
      model_last = model_next_last(exp, model_last);
      req_data[8*exp +: 8] = 8'($urandom);
      if (t == 2 * N - 1) req_valid = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int idx, cyc, exp, k, dr0, a0;
    logic [7:0] b;
    wait_cfg = 3;
    dr0 = dr_writes; a0 = acks;
    req_data[23:16] = 8'($urandom);
    req_valid = 4'b0100;
    k = 0;
    while (k < 40 && !(wb_cyc && wb_we)) begin @(negedge clk); k++; end
    n_vec++; if (!(wb_cyc && wb_we)) begin n_err++; $display("FAIL rstmid_reach_write: got cyc&we 0 want 1"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
      n_err++; $display("FAIL rstmid_cyc_drop: got cyc/stb %0b%0b want 00", wb_cyc, wb_stb); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    repeat (2) @(negedge clk);
    n_vec++; if (dr_writes - dr0 !== 0 || acks - a0 !== 0) begin
      n_err++; $display("FAIL rstmid_lost: got writes %0d acks %0d want 0 0", dr_writes - dr0, acks - a0); end
    wait_cfg = 0;
    model_last = N - 1;
    req_data[7:0] = 8'($urandom);
    req_valid = 4'b0101;
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++) begin
      exp = model_pick(req_valid, model_last);
      b = req_data[8*exp +: 8];
      wait_ack(60, idx, cyc);
      n_vec++; if (idx !== exp) begin n_err++; $display("FAIL rstmid_grant[%0d]: got %0d want %0d", t, idx, exp); end
      n_vec++; if (last_wdat !== {24'd0, b}) begin n_err++; $display("FAIL rstmid_wdat[%0d]: got %h want %h", t, last_wdat, {24'd0, b}); end
      model_last = model_next_last(exp, model_last);
      req_valid[exp] = 1'b0;
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int idx, cyc, exp;
    logic [N-1:0] vld;
    logic [7:0] b;
    vld = N'($urandom_range(1, (1 << N) - 1));
    for (int k = 0; k < N; k++) req_data[8*k +: 8] = 8'($urandom);
    for (int t = 0; t < 40; t++) begin
      wait_cfg = $urandom_range(0, 2);
      full_budget += $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) err_budget += 1;
      req_valid = vld;
      exp = model_pick(vld, model_last);
      b = req_data[8*exp +: 8];
      wait_ack(400, idx, cyc);
      n_vec++; if (idx !== exp) begin n_err++; $display("FAIL rand_grant[%0d]: got %0d want %0d", t, idx, exp); end
      n_vec++; if (last_wdat !== {24'd0, b}) begin n_err++; $display("FAIL rand_wdat[%0d]: got %h want %h", t, last_wdat, {24'd0, b}); end
      model_last = model_next_last(exp, model_last);
      req_data[8*exp +: 8] = 8'($urandom);
      vld[exp] = 1'($urandom_range(0, 1));
      vld = vld | (N'($urandom) & N'($urandom));
      if (vld == '0) vld[$urandom_range(0, N - 1)] = 1'b1;
    end
    req_valid = '0;
    wait_cfg = 0;
    @(negedge clk);
  endtask

`ifdef UART_SCHED_PRIO_EN
  task automatic test_prio();
    int idx, cyc, exp;
    req_data[7:0] = 8'($urandom);
    req_data[23:16] = 8'($urandom);
    req_valid = 4'b0101;
    for (int t = 0; t < 5; t++) begin
      exp = model_pick(req_valid, model_last);
      wait_ack(60, idx, cyc);
      n_vec++; if (idx !== exp) begin n_err++; $display("FAIL prio_grant[%0d]: got %0d want %0d", t, idx, exp); end
      model_last = model_next_last(exp, model_last);
      if (t == 3) req_valid[0] = 1'b0;
    end
    req_valid = '0;
    @(negedge clk);
  endtask
`endif

  task automatic test_protocol();
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL bus_protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_latch();
    test_fr_full();
    test_dr_err();
    test_round_robin();
    test_reset_mid();
    test_random();
`ifdef UART_SCHED_PRIO_EN
    test_prio();
`endif
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
